// File: rtl/player_ctrl_pkg.sv
// player_pkg: shared definitions for the per-player controller.
//   - coordinate / sum widths (sums carry one extra bit so edge tests never wrap)
//   - screen bounds, FSM state enum, default keymaps for both players
package player_pkg;

  localparam int COORD_W = 10;

  typedef logic [COORD_W-1:0] coord_t;
  typedef logic [COORD_W:0]   sum_t;

  localparam sum_t SCREEN_MAX_X = sum_t'(639);
  localparam sum_t SCREEN_MAX_Y = sum_t'(479);

  typedef enum logic [1:0] {
    ALIVE = 2'd0,
    HIT   = 2'd1,
    DEAD  = 2'd2
  } state_e;

  // Player 1: arrow keys + 'P'
  localparam logic [7:0] P1_KEY_UP    = 8'h52;
  localparam logic [7:0] P1_KEY_DOWN  = 8'h51;
  localparam logic [7:0] P1_KEY_LEFT  = 8'h50;
  localparam logic [7:0] P1_KEY_RIGHT = 8'h4F;
  localparam logic [7:0] P1_KEY_BOMB  = 8'h13;

  // Player 2: WASD + space
  localparam logic [7:0] P2_KEY_UP    = 8'h1A;
  localparam logic [7:0] P2_KEY_DOWN  = 8'h16;
  localparam logic [7:0] P2_KEY_LEFT  = 8'h04;
  localparam logic [7:0] P2_KEY_RIGHT = 8'h07;
  localparam logic [7:0] P2_KEY_BOMB  = 8'h2C;

endpackage

// File: rtl/player_ctrl_aabb.sv
// aabb_overlap: combinational half-open box overlap test.
//   ax_i/ay_i/aw_i/ah_i : box A top-left and size
//   bx_i/by_i/bw_i/bh_i : box B top-left and size
//   overlap_o           : 1 when the boxes share at least one pixel
// Right/bottom edges are formed 11 bits wide so boxes near 1023 never wrap.
module aabb_overlap
  import player_pkg::*;
(
  input  logic [COORD_W-1:0] ax_i,
  input  logic [COORD_W-1:0] ay_i,
  input  logic [COORD_W-1:0] aw_i,
  input  logic [COORD_W-1:0] ah_i,
  input  logic [COORD_W-1:0] bx_i,
  input  logic [COORD_W-1:0] by_i,
  input  logic [COORD_W-1:0] bw_i,
  input  logic [COORD_W-1:0] bh_i,
  output logic               overlap_o
);

  sum_t a_l, a_r, a_t, a_b;
  sum_t b_l, b_r, b_t, b_b;

  assign a_l = sum_t'(ax_i);
  assign a_t = sum_t'(ay_i);
  assign a_r = sum_t'(ax_i) + sum_t'(aw_i);
  assign a_b = sum_t'(ay_i) + sum_t'(ah_i);
  assign b_l = sum_t'(bx_i);
  assign b_t = sum_t'(by_i);
  assign b_r = sum_t'(bx_i) + sum_t'(bw_i);
  assign b_b = sum_t'(by_i) + sum_t'(bh_i);

  assign overlap_o = (a_l < b_r) && (b_l < a_r) && (a_t < b_b) && (b_t < a_b);

endmodule

// File: rtl/player_ctrl.sv
// player_ctrl: one Bomberman player, advanced once per frame.
//   frame_clk, Reset (async, active-high)
//   keycode                        : current key, 0 = none
//   wall_x/wall_y/wall_s           : packed square walls, 10 bits each
//   bomb_x/bomb_y/bomb_xs/bomb_ys  : packed explosion boxes, bomb_active marks lethal ones
//   bomb_drop / damage             : one-frame pulses
//   collide                        : box overlaps an active explosion (registered)
//   heart / dead                   : remaining hearts, terminal state flag
//   userX / userY                  : sprite top-left
module player_ctrl
  import player_pkg::*;
#(
  parameter int         NUM_WALLS     = 4,
  parameter int         NUM_BOMBS     = 2,
  parameter int         X_SIZE        = 19,
  parameter int         Y_SIZE        = 26,
  parameter int         STEP          = 1,
  parameter int         START_X       = 543,
  parameter int         START_Y       = 415,
  parameter int         LIVES         = 3,
  parameter int         IFRAMES       = 60,
  parameter int         BOMB_COOLDOWN = 90,
  parameter logic [7:0] KEY_UP        = P1_KEY_UP,
  parameter logic [7:0] KEY_DOWN      = P1_KEY_DOWN,
  parameter logic [7:0] KEY_LEFT      = P1_KEY_LEFT,
  parameter logic [7:0] KEY_RIGHT     = P1_KEY_RIGHT,
  parameter logic [7:0] KEY_BOMB      = P1_KEY_BOMB
) (
  input  logic                         frame_clk,
  input  logic                         Reset,
  input  logic [7:0]                   keycode,
  input  logic [COORD_W*NUM_WALLS-1:0] wall_x,
  input  logic [COORD_W*NUM_WALLS-1:0] wall_y,
  input  logic [COORD_W*NUM_WALLS-1:0] wall_s,
  input  logic [COORD_W*NUM_BOMBS-1:0] bomb_x,
  input  logic [COORD_W*NUM_BOMBS-1:0] bomb_y,
  input  logic [COORD_W*NUM_BOMBS-1:0] bomb_xs,
  input  logic [COORD_W*NUM_BOMBS-1:0] bomb_ys,
  input  logic [NUM_BOMBS-1:0]         bomb_active,
  output logic                         bomb_drop,
  output logic                         damage,
  output logic                         collide,
  output logic [2:0]                   heart,
  output logic                         dead,
  output logic [COORD_W-1:0]           userX,
  output logic [COORD_W-1:0]           userY
);

  localparam int IFR_W = (IFRAMES < 1) ? 1 : $clog2(IFRAMES + 1);
  localparam int CD_W  = (BOMB_COOLDOWN < 1) ? 1 : $clog2(BOMB_COOLDOWN + 1);
  typedef logic [IFR_W-1:0] ifr_t;
  typedef logic [CD_W-1:0]  cd_t;

  localparam coord_t STEP_C  = coord_t'(STEP);
  localparam coord_t XS      = coord_t'(X_SIZE);
  localparam coord_t YS      = coord_t'(Y_SIZE);
  localparam coord_t SPAWN_X = coord_t'(START_X);
  localparam coord_t SPAWN_Y = coord_t'(START_Y);

  state_e     state_q, state_d;
  coord_t     x_q, x_d, y_q, y_d;
  logic [2:0] heart_q, heart_d;
  ifr_t       ifr_q, ifr_d;
  cd_t        cd_q, cd_d;
  logic [7:0] prev_key_q;
  logic       drop_q, drop_d, damage_q, damage_d, collide_q, collide_d;

  coord_t               cand_x, cand_y;
  logic                 step_ok, move_ok, hit_any;
  logic [NUM_WALLS-1:0] wall_hit;
  logic [NUM_BOMBS-1:0] bomb_hit;

  // Candidate position; edge limits are checked before the move so left/up never underflow.
  always_comb begin
    cand_x  = x_q;
    cand_y  = y_q;
    step_ok = 1'b0;
    if (keycode == KEY_LEFT) begin
      step_ok = (x_q >= STEP_C);
      cand_x  = x_q - STEP_C;
    end else if (keycode == KEY_RIGHT) begin
      step_ok = (sum_t'(x_q) + sum_t'(STEP_C) + sum_t'(XS) <= SCREEN_MAX_X);
      cand_x  = x_q + STEP_C;
    end else if (keycode == KEY_UP) begin
      step_ok = (y_q >= STEP_C);
      cand_y  = y_q - STEP_C;
    end else if (keycode == KEY_DOWN) begin
      step_ok = (sum_t'(y_q) + sum_t'(STEP_C) + sum_t'(YS) <= SCREEN_MAX_Y);
      cand_y  = y_q + STEP_C;
    end
  end

  for (genvar i = 0; i < NUM_WALLS; i++) begin : g_wall
    aabb_overlap u_wall (
      .ax_i     (cand_x),
      .ay_i     (cand_y),
      .aw_i     (XS),
      .ah_i     (YS),
      .bx_i     (wall_x[COORD_W*i +: COORD_W]),
      .by_i     (wall_y[COORD_W*i +: COORD_W]),
      .bw_i     (wall_s[COORD_W*i +: COORD_W]),
      .bh_i     (wall_s[COORD_W*i +: COORD_W]),
      .overlap_o(wall_hit[i])
    );
  end

  // Explosions are tested against the current (not candidate) box.
  for (genvar i = 0; i < NUM_BOMBS; i++) begin : g_bomb
    aabb_overlap u_bomb (
      .ax_i     (x_q),
      .ay_i     (y_q),
      .aw_i     (XS),
      .ah_i     (YS),
      .bx_i     (bomb_x[COORD_W*i +: COORD_W]),
      .by_i     (bomb_y[COORD_W*i +: COORD_W]),
      .bw_i     (bomb_xs[COORD_W*i +: COORD_W]),
      .bh_i     (bomb_ys[COORD_W*i +: COORD_W]),
      .overlap_o(bomb_hit[i])
    );
  end

  assign move_ok   = step_ok && !(|wall_hit);
  assign hit_any   = |(bomb_hit & bomb_active);
  assign collide_d = hit_any;

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    heart_d  = heart_q;
    ifr_d    = ifr_q;
    damage_d = 1'b0;
    unique case (state_q)
      ALIVE: begin
        if (hit_any) begin
          // A hit respawns the player and takes priority over any move this frame.
          damage_d = 1'b1;
          heart_d  = heart_q - 3'd1;
          x_d      = SPAWN_X;
          y_d      = SPAWN_Y;
          if (heart_q == 3'd1) begin
            state_d = DEAD;
          end else begin
            state_d = HIT;
            ifr_d   = ifr_t'(IFRAMES);
          end
        end else if (move_ok) begin
          x_d = cand_x;
          y_d = cand_y;
        end
      end
      HIT: begin
        if (move_ok) begin
          x_d = cand_x;
          y_d = cand_y;
        end
        if (ifr_q <= ifr_t'(1)) begin
          state_d = ALIVE;
          ifr_d   = '0;
        end else begin
          ifr_d = ifr_q - ifr_t'(1);
        end
      end
      DEAD: begin
      end
      default: state_d = ALIVE;
    endcase
  end

  // Bomb requests fire on the press edge only and are rate-limited by the cooldown.
  always_comb begin
    drop_d = (state_q != DEAD) && (keycode == KEY_BOMB) &&
             (prev_key_q != KEY_BOMB) && (cd_q == '0);
    cd_d   = cd_q;
    if (drop_d) begin
      cd_d = cd_t'(BOMB_COOLDOWN);
    end else if (cd_q != '0) begin
      cd_d = cd_q - cd_t'(1);
    end
  end

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state_q    <= ALIVE;
      x_q        <= SPAWN_X;
      y_q        <= SPAWN_Y;
      heart_q    <= 3'(LIVES);
      ifr_q      <= '0;
      cd_q       <= '0;
      prev_key_q <= '0;
      drop_q     <= 1'b0;
      damage_q   <= 1'b0;
      collide_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      heart_q    <= heart_d;
      ifr_q      <= ifr_d;
      cd_q       <= cd_d;
      prev_key_q <= keycode;
      drop_q     <= drop_d;
      damage_q   <= damage_d;
      collide_q  <= collide_d;
    end
  end

  assign bomb_drop = drop_q;
  assign damage    = damage_q;
  assign collide   = collide_q;
  assign heart     = heart_q;
  assign dead      = (state_q == DEAD);
  assign userX     = x_q;
  assign userY     = y_q;

endmodule

// File: tb/tb_player_ctrl.sv
// Scoreboard bench for player_ctrl: stimulus queues expected output values
// tagged with the frame they belong to; a monitor compares them after each edge.
module tb_player_ctrl;

  localparam int NW = 4;
  localparam int NB = 2;

  localparam int F_X    = 0;
  localparam int F_Y    = 1;
  localparam int F_HRT  = 2;
  localparam int F_DEAD = 3;
  localparam int F_DROP = 4;
  localparam int F_DMG  = 5;
  localparam int F_COL  = 6;

  logic            frame_clk = 1'b0;
  logic            Reset;
  logic [7:0]      keycode;
  logic [10*NW-1:0] wall_x, wall_y, wall_s;
  logic [10*NB-1:0] bomb_x, bomb_y, bomb_xs, bomb_ys;
  logic [NB-1:0]   bomb_active;
  logic            bomb_drop, damage, collide, dead;
  logic [2:0]      heart;
  logic [9:0]      userX, userY;

  player_ctrl dut (
    .frame_clk  (frame_clk),
    .Reset      (Reset),
    .keycode    (keycode),
    .wall_x     (wall_x),
    .wall_y     (wall_y),
    .wall_s     (wall_s),
    .bomb_x     (bomb_x),
    .bomb_y     (bomb_y),
    .bomb_xs    (bomb_xs),
    .bomb_ys    (bomb_ys),
    .bomb_active(bomb_active),
    .bomb_drop  (bomb_drop),
    .damage     (damage),
    .collide    (collide),
    .heart      (heart),
    .dead       (dead),
    .userX      (userX),
    .userY      (userY)
  );

  always #5 frame_clk = ~frame_clk;

  typedef struct {
    int    fr;
    string name;
    int    fld;
    int    val;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;

  always @(posedge frame_clk) cyc <= cyc + 1;

  function automatic int actual(input int f);
    case (f)
      F_X:     return int'(userX);
      F_Y:     return int'(userY);
      F_HRT:   return int'(heart);
      F_DEAD:  return int'(dead);
      F_DROP:  return int'(bomb_drop);
      F_DMG:   return int'(damage);
      default: return int'(collide);
    endcase
  endfunction

  // Monitor: compare every expectation due at this frame.
  always @(posedge frame_clk) begin
    #1;
    while (q.size() > 0 && q[0].fr <= cyc) begin
      exp_t e;
      int   a;
      e = q.pop_front();
      a = actual(e.fld);
      n_checks++;
      if (a == e.val) n_pass++;
      else $display("FAIL %s (frame %0d): got %0d, expected %0d", e.name, cyc, a, e.val);
    end
  end

  task automatic ex(input string nm, input int f, input int v);
    exp_t e;
    e.fr   = cyc + 1;
    e.name = nm;
    e.fld  = f;
    e.val  = v;
    q.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge frame_clk);
      #2;
    end
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    tick(1);
    Reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    Reset       = 1'b1;
    keycode     = 8'h00;
    wall_x      = '0;
    wall_y      = '0;
    wall_s      = '0;
    bomb_x      = '0;
    bomb_y      = '0;
    bomb_xs     = '0;
    bomb_ys     = '0;
    bomb_active = '0;

    // Reset values
    ex("rst_x", F_X, 543);    ex("rst_y", F_Y, 415);   ex("rst_heart", F_HRT, 3);
    ex("rst_dead", F_DEAD, 0); ex("rst_drop", F_DROP, 0); ex("rst_dmg", F_DMG, 0);
    ex("rst_col", F_COL, 0);
    tick(1);
    Reset = 1'b0;

    // Move left 10 frames with a wall at (0,0,32), then release
    wall_x[9:0] = 10'd0; wall_y[9:0] = 10'd0; wall_s[9:0] = 10'd32;
    keycode = 8'h50;
    ex("left_1", F_X, 542);
    tick(1);
    tick(8);
    ex("left_10_x", F_X, 533); ex("left_10_y", F_Y, 415);
    tick(1);
    keycode = 8'h00;
    ex("release_x", F_X, 533);
    tick(6);
    ex("release_hold_x", F_X, 533);
    tick(1);

    // Move right into a wall at (563,415,32)
    do_reset();
    wall_x[9:0] = 10'd563; wall_y[9:0] = 10'd415; wall_s[9:0] = 10'd32;
    keycode = 8'h4F;
    ex("wall_step_x", F_X, 544);
    tick(1);
    tick(3);
    ex("wall_block_x", F_X, 544); ex("wall_no_col", F_COL, 0);
    tick(1);
    keycode = 8'h00;
    wall_s[9:0] = 10'd0;

    // Bomb: held key gives one pulse; cooldown blocks a re-press at +50, allows at +95
    do_reset();
    keycode = 8'h13;
    ex("bomb_first", F_DROP, 1);
    tick(1);
    ex("bomb_held_2", F_DROP, 0);
    tick(1);
    tick(197);
    ex("bomb_held_200", F_DROP, 0);
    tick(1);
    keycode = 8'h00;
    tick(1);
    keycode = 8'h13;
    ex("bomb_repress", F_DROP, 1);
    tick(1);
    keycode = 8'h00;
    tick(49);
    keycode = 8'h13;
    ex("bomb_cooldown_50", F_DROP, 0);
    tick(1);
    keycode = 8'h00;
    tick(44);
    keycode = 8'h13;
    ex("bomb_after_95", F_DROP, 1);
    tick(1);
    keycode = 8'h00;
    ex("bomb_pulse_end", F_DROP, 0);
    tick(1);

    // Damage with invulnerability frames, then death
    Reset = 1'b1;
    bomb_x[9:0] = 10'd540; bomb_y[9:0] = 10'd410;
    bomb_xs[9:0] = 10'd30; bomb_ys[9:0] = 10'd40;
    bomb_active = 2'b01;
    tick(1);
    Reset = 1'b0;
    ex("hit1_dmg", F_DMG, 1); ex("hit1_heart", F_HRT, 2);
    ex("hit1_x", F_X, 543);   ex("hit1_col", F_COL, 1);
    tick(1);
    ex("iframe_dmg", F_DMG, 0); ex("iframe_col", F_COL, 1); ex("iframe_heart", F_HRT, 2);
    tick(1);
    tick(58);
    ex("iframe_last_dmg", F_DMG, 0); ex("iframe_last_heart", F_HRT, 2);
    tick(1);
    ex("hit2_dmg", F_DMG, 1); ex("hit2_heart", F_HRT, 1);
    tick(1);
    tick(60);
    ex("hit3_dmg", F_DMG, 1); ex("hit3_heart", F_HRT, 0); ex("hit3_dead", F_DEAD, 1);
    tick(1);
    keycode = 8'h13;
    ex("dead_no_drop", F_DROP, 0); ex("dead_no_dmg", F_DMG, 0); ex("dead_level", F_DEAD, 1);
    tick(1);
    keycode = 8'h50;
    tick(4);
    ex("dead_frozen_x", F_X, 543); ex("dead_heart", F_HRT, 0);
    tick(1);
    keycode = 8'h00;
    Reset = 1'b1;
    bomb_active = 2'b00;
    ex("revive_heart", F_HRT, 3); ex("revive_dead", F_DEAD, 0);
    tick(1);
    Reset = 1'b0;

    // Right edge clamp, then top edge clamp
    keycode = 8'h4F;
    tick(89);
    ex("right_edge_x", F_X, 620);
    tick(1);
    keycode = 8'h52;
    ex("up_1_y", F_Y, 414);
    tick(1);
    tick(418);
    ex("top_edge_y", F_Y, 0);
    tick(1);
    tick(4);
    ex("top_hold_y", F_Y, 0); ex("top_hold_x", F_X, 620);
    tick(1);
    keycode = 8'h00;

    tick(3);
    n_checks++;
    if (q.size() == 0) n_pass++;
    else $display("FAIL scoreboard_drain: got %0d pending, expected 0", q.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/player_ctrl.md
Name: player_ctrl

Overview:
- Parametrised per-player controller for the Bomberman core; one instance per player, keymap selected by parameters.
- Moves a fixed-size sprite box one step per frame under keyboard control, with blocking against the screen edges and NUM_WALLS walls.
- Emits edge-triggered, rate-limited bomb drops.
- Tracks hearts across NUM_BOMBS explosion boxes, with respawn, invulnerability frames and a terminal dead state.

Parameters:
- NUM_WALLS, 4, number of square wall boxes checked.
- NUM_BOMBS, 2, number of explosion boxes checked.
- X_SIZE, 19, sprite width in pixels.
- Y_SIZE, 26, sprite height in pixels.
- STEP, 1, pixels moved per frame.
- START_X, 543, spawn/respawn X.
- START_Y, 415, spawn/respawn Y.
- LIVES, 3, initial hearts (1..7).
- IFRAMES, 60, invulnerable frames after a hit.
- BOMB_COOLDOWN, 90, minimum frames between bomb_drop pulses.
- KEY_UP/KEY_DOWN/KEY_LEFT/KEY_RIGHT/KEY_BOMB, 8'h52/8'h51/8'h50/8'h4F/8'h13, keymap.

Ports:
- frame_clk  in  1  frame-rate clock; all state advances once per frame.
- Reset  in  1  asynchronous, active-high.
- keycode  in  8  current key; 0 = none.
- wall_x, wall_y, wall_s  in  10*NUM_WALLS each  packed wall top-left corner and side length; wall i occupies bits [10i+9:10i].
- bomb_x, bomb_y, bomb_xs, bomb_ys  in  10*NUM_BOMBS each  packed explosion boxes.
- bomb_active  in  NUM_BOMBS  explosion i currently lethal.
- bomb_drop  out  1  one-frame pulse requesting a bomb at userX/userY.
- damage  out  1  one-frame pulse on a registered hit.
- collide  out  1  level: box overlaps any active explosion this frame.
- heart  out  3  remaining hearts.
- dead  out  1  level, heart = 0.
- userX, userY  out  10 each  sprite top-left.

Behaviour:
- Reset values:
  - userX = START_X, userY = START_Y, heart = LIVES.
  - bomb_drop = damage = collide = dead = 0.
  - State ALIVE; iframe counter and cooldown counter = 0; previous-key register = 0.
- Overlap test is half-open AABB: ax < bx+bw && bx < ax+aw, and the same on Y. All sums are computed 11 bits wide; there is no 10-bit wrap.
- Movement (ALIVE and HIT):
  - The candidate position is the current position plus or minus STEP on one axis, per keycode. Any other key gives no motion, and the sprite does not keep drifting once the key is released.
  - The candidate is rejected (position held) when any of these is true:
    - Left/up: coordinate < STEP.
    - Right: candidate X + X_SIZE > 639.
    - Down: candidate Y + Y_SIZE > 479.
    - The candidate box overlaps any wall.
  - Otherwise the position register loads the candidate. Latency is 1 frame from key to position.
- Bomb:
  - bomb_drop = 1 for exactly one frame when keycode == KEY_BOMB, the previous keycode != KEY_BOMB, and the cooldown is 0. The cooldown then loads BOMB_COOLDOWN and decrements each frame down to 0.
  - Holding KEY_BOMB yields a single pulse.
  - No pulse while in DEAD.
- Damage:
  - collide is registered from the current box overlapping any bomb whose bomb_active bit is 1.
- State machine:
  - ALIVE: if the hit condition holds, pulse damage, decrement heart, and load userX/userY with START_X/START_Y; that same frame the hit overrides movement.
    - heart reaching 0 goes to DEAD.
    - Otherwise go to HIT with the iframe counter = IFRAMES.
  - HIT: movement and bombs still work; overlaps are ignored for damage, but collide is still reported. The counter decrements each frame; at 1 it returns to ALIVE.
  - DEAD: position frozen; dead = 1; bomb_drop and damage stay 0. Only Reset exits.
- Reset mid-frame clears everything asynchronously, including a pending bomb_drop or damage pulse.

Decomposition:
- Package player_pkg:
  - Screen bounds 639/479.
  - Coordinate width 10.
  - State enum {ALIVE, HIT, DEAD}.
  - Default keymap constants for both players.
- One sub-module, aabb_overlap: combinational, 11-bit internal math. Instantiated NUM_WALLS times for the candidate box and NUM_BOMBS times for the current box.

Test Plan:
- Reset, then keycode 8'h50 held for 10 frames, one wall at (0,0,s=32) → userX = 533, userY = 415. Release the key → position constant thereafter.
- Wall at (563,415,s=32), keycode 8'h4F held 5 frames from X = 543 → X reaches 544 then holds; no overlap ever.
- KEY_BOMB held 200 frames → bomb_drop pulses at frame 1 only. Release, press again at frame 50 → no pulse; press at frame 95 → a pulse.
- Active bomb box covering the spawn → damage pulse, heart 3→2, position = spawn. No further damage for 60 frames despite collide = 1; a second hit on frame 61.
- Three hits with spacing > IFRAMES → heart = 0, dead = 1. Keys and bombs are ignored; Reset restores heart = 3, dead = 0.
- keycode 8'h52 held at Y = 0 with STEP = 1 → Y stays 0, no underflow to 1023.
